tx_byte_shifter: RTL
====================

Name: tx_byte_shifter

Overview:
- Byte transmitter and bit timer for the USB TX path. Sits directly downstream of the TX packet FSM.
- Takes the FSM's byte/select/load controls plus the FIFO data byte, and serializes bytes LSB-first at the bit rate.
- Auto-reloads the next byte back-to-back, reports each byte completion, and flags end-of-data after a fixed number of payload bytes.
- Feeds the bit stuffer / NRZI stage and honours its stall request.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit period (≥2).
- DATA_BYTES, 64, payload bytes per data packet before eod fires (1..127).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_enable  in  1  timer/shifter enable (FSM Tim_en)
- cnt_rst  in  1  synchronous clear of payload byte counter (FSM Tim_rst)
- load_en  in  1  start transmission from IDLE
- select  in  1  1 = fsm_byte, 0 = fifo_byte
- fsm_byte  in  8  byte from TX FSM
- fifo_byte  in  8  byte from TX FIFO read port
- stuff_stall  in  1  downstream stuffer inserting a bit this period; hold shift
- serial_out  out  1  current data bit (shreg[0])
- serial_valid  out  1  high while shifting
- bit_strobe  out  1  one-cycle pulse at end of every bit period
- load_byte  out  1  one-cycle pulse: byte completed, next byte latched
- eod  out  1  one-cycle pulse coincident with load_byte for payload byte DATA_BYTES

Behaviour:
- Reset values:
  - state IDLE; shreg, clk_cnt, bit_idx, byte_cnt all 0.
  - serial_out, serial_valid, bit_strobe, load_byte, eod all 0.
- mux_byte = select ? fsm_byte : fifo_byte, sampled only at load points.
- IDLE:
  - If load_en && tx_enable: shreg <= mux_byte, clk_cnt <= 0, bit_idx <= 0, go to SHIFT.
  - load_en without tx_enable is ignored.
- SHIFT:
  - clk_cnt counts 0..CLKS_PER_BIT-1 and wraps. tick = (clk_cnt == CLKS_PER_BIT-1).
  - bit_strobe is registered and high the cycle after each tick, so it pulses every period, stalled or not.
  - On tick with stuff_stall = 1: shreg and bit_idx hold; the period is consumed by the stuffed bit.
  - On tick with stuff_stall = 0 and bit_idx < 7: shreg >>= 1, bit_idx++.
  - On tick with stuff_stall = 0 and bit_idx == 7, the byte is complete:
    - shreg <= mux_byte, bit_idx <= 0.
    - load_byte pulses the next cycle.
    - Stays in SHIFT (auto-reload) for back-to-back bytes.
  - tx_enable = 0 in SHIFT: abort to IDLE next edge. clk_cnt and bit_idx clear. No load_byte or eod. A pulse already registered still completes its single cycle.
  - load_en in SHIFT is ignored.
- serial_valid = (state == SHIFT). serial_out = shreg[0] in SHIFT, 0 in IDLE.
- Byte counter (7 bit):
  - cnt_rst = 1 clears byte_cnt to 0 and has priority over increment in the same cycle.
  - Otherwise it increments on each byte completion.
  - Completion with byte_cnt == DATA_BYTES-1: eod pulses together with load_byte, and byte_cnt <= 0.
  - Bytes after eod (CRC) count up from 0 again; no further eod unless DATA_BYTES is reached again.
- Latency: first bit valid the cycle after load_en. load_byte appears 8*CLKS_PER_BIT + 1 cycles after load_en, with no stalls.
- Async reset mid-byte: immediate return to reset values.

Optional Feature:
- Macro TX_BYTE_COUNT_EN.
- Defined: adds output port byte_count [6:0], driven directly by the internal payload counter, for debug/timer visibility.
- Undefined: no port. Counter remains internal and behaviour is otherwise identical.

Test Plan:
- Basic load (CLKS_PER_BIT=8): select=1, fsm_byte=8'h80, load_en for 1 cycle → serial_out = 0,0,0,0,0,0,0,1, each held 8 cycles; bit_strobe every 8 cycles; load_byte single pulse at cycle 65.
- Auto-reload: SYNC 8'h80, then fsm_byte=8'h4B held → after load_byte, 8'h4B shifts LSB-first (1,1,0,1,0,0,1,0) with no idle gap; serial_valid stays 1.
- EOD (DATA_BYTES=4): cnt_rst pulsed coincident with PID load_byte, select=0, fifo_byte = 8'hA5..A8 → eod pulses with the 4th data load_byte only; the next two completions give load_byte without eod.
- Stall: stuff_stall=1 on the tick ending bit 2 of 8'hFF → bit 3 starts one period late; load_byte is delayed by exactly 8 cycles (73 vs 65).
- Abort: tx_enable drops mid-byte at bit 4 → IDLE next cycle; serial_valid = 0; no load_byte/eod. A later load_en restarts cleanly at bit 0.
- Reset: n_rst low mid-byte → all outputs 0 immediately. After release, load_en with 8'h5A transmits normally; byte counter starts at 0.

Source files
------------

// File: rtl/tx_byte_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_byte_shifter
//  Description : USB TX byte transmitter and bit timer. Loads a byte from the
//                TX FSM or the TX FIFO, shifts it out LSB-first at the bit
//                rate, auto-reloads back-to-back bytes, flags each byte
//                completion and raises eod after DATA_BYTES payload bytes.
//                Honours the downstream bit-stuffer stall request.
//  Options     : TX_BYTE_COUNT_EN - exposes the payload byte counter on the
//                byte_count output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_byte_shifter #(
  parameter int CLKS_PER_BIT = 8,   // system clocks per USB bit period (>= 2)
  parameter int DATA_BYTES   = 64   // payload bytes per packet before eod (1..127)
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_enable,
  input  logic       cnt_rst,
  input  logic       load_en,
  input  logic       select,
  input  logic [7:0] fsm_byte,
  input  logic [7:0] fifo_byte,
  input  logic       stuff_stall,
  output logic       serial_out,
  output logic       serial_valid,
  output logic       bit_strobe,
  output logic       load_byte,
`ifdef TX_BYTE_COUNT_EN
  output logic       eod,
  output logic [6:0] byte_count
`else
  output logic       eod
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] c_LAST_BIT = 3'd7;
  localparam logic [6:0] c_EOD_CNT  = 7'(DATA_BYTES - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [7:0]           r_shreg;
  logic [c_CNT_W-1:0]   r_clk_cnt;
  logic [2:0]           r_bit_idx;
  logic [6:0]           r_byte_cnt;
  logic                 r_bit_strobe;
  logic                 r_load_byte;
  logic                 r_eod;

  // --------------------------------------------------------------------------
  // Next-state / combinational signals
  // --------------------------------------------------------------------------
  state_t               w_state_nxt;
  logic [7:0]           w_shreg_nxt;
  logic [c_CNT_W-1:0]   w_clk_cnt_nxt;
  logic [2:0]           w_bit_idx_nxt;
  logic                 w_strobe_nxt;
  logic                 w_byte_done;
  logic                 w_tick;
  logic                 w_eod_hit;
  logic [7:0]           w_mux_byte;

  // The source byte only matters at load points (start from IDLE or reload).
  assign w_mux_byte = select ? fsm_byte : fifo_byte;

  // Last clock of the current bit period.
  assign w_tick = (r_clk_cnt == c_CNT_MAX);

  // Byte completion that lands on the final payload byte.
  assign w_eod_hit = w_byte_done && (r_byte_cnt == c_EOD_CNT);

  // State register plus shift datapath and registered pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= ST_IDLE;
      r_shreg      <= 8'd0;
      r_clk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_bit_strobe <= 1'b0;
      r_load_byte  <= 1'b0;
      r_eod        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_clk_cnt    <= w_clk_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_bit_strobe <= w_strobe_nxt;
      r_load_byte  <= w_byte_done;
      r_eod        <= w_eod_hit;
    end
  end

  // Next-state, bit timer and shifter decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_strobe_nxt  = 1'b0;
    w_byte_done   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = 3'd0;
        // A load request is only honoured while the timer is enabled.
        if (load_en && tx_enable) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = w_mux_byte;
        end
      end

      ST_SHIFT: begin
        if (!tx_enable) begin
          // Abort: drop the byte in flight, no completion reported.
          w_state_nxt   = ST_IDLE;
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_clk_cnt_nxt = w_tick ? '0 : (r_clk_cnt + c_CNT_W'(1));
          if (w_tick) begin
            // The strobe marks every bit period, including stuffed ones.
            w_strobe_nxt = 1'b1;
            // A stuffed bit consumes the period without advancing the byte.
            if (!stuff_stall) begin
              if (r_bit_idx == c_LAST_BIT) begin
                // Byte done: reload the next byte back-to-back.
                w_shreg_nxt   = w_mux_byte;
                w_bit_idx_nxt = 3'd0;
                w_byte_done   = 1'b1;
              end else begin
                w_shreg_nxt   = {1'b0, r_shreg[7:1]};
                w_bit_idx_nxt = r_bit_idx + 3'd1;
              end
            end
          end
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = 3'd0;
      end
    endcase
  end

  // Payload byte counter; an explicit clear wins over a completion increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_byte_cnt <= 7'd0;
    end else if (cnt_rst) begin
      r_byte_cnt <= 7'd0;
    end else if (w_byte_done) begin
      r_byte_cnt <= w_eod_hit ? 7'd0 : (r_byte_cnt + 7'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign serial_valid = (r_state == ST_SHIFT);
  assign serial_out   = (r_state == ST_SHIFT) ? r_shreg[0] : 1'b0;
  assign bit_strobe   = r_bit_strobe;
  assign load_byte    = r_load_byte;
  assign eod          = r_eod;

`ifdef TX_BYTE_COUNT_EN
  assign byte_count   = r_byte_cnt;
`endif

endmodule
`default_nettype wire
